bcd_digit_splitter: RTL and testbench

- Sequential binary-to-BCD converter that feeds the four 7-segment digit decoders in the display path.
- Accepts a 14-bit unsigned value on a start pulse.
- Runs shift-add-3 (double dabble), one bit per cycle.
- Presents four digit codes (0-9, 10 = dash, 11 = blank) held stable until the next conversion completes.

---
 rtl/display_pkg.sv | 20 ++
 rtl/bcd_digit_splitter_if.sv | 25 ++
 rtl/bcd_add3.sv | 12 +
 rtl/bcd_digit_splitter.sv | 124 ++++++++++++
 tb/tb_bcd_digit_splitter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display path: widths, digit codes and FSM encoding.
package display_pkg;

  localparam int unsigned IN_W   = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned CODE_W = 14;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BCD_W  = NIB_W * DIGITS;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned MAX_DISPLAY = 9999;

  localparam logic [NIB_W-1:0] CODE_DASH  = 4'd10;
  localparam logic [NIB_W-1:0] CODE_BLANK = 4'd11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FORMAT = 2'd2;

endpackage

// File: rtl/bcd_digit_splitter_if.sv
// Request/result bundle between the display controller and the BCD splitter.
interface bcd_digit_splitter_if;
  import display_pkg::*;

  logic              start;
  logic [IN_W-1:0]   value;
  logic              blank_zeros;
  logic              busy;
  logic              done;
  logic [CODE_W-1:0] dig0;
  logic [CODE_W-1:0] dig1;
  logic [CODE_W-1:0] dig2;
  logic [CODE_W-1:0] dig3;

  modport master (
    output start, value, blank_zeros,
    input  busy, done, dig0, dig1, dig2, dig3
  );

  modport slave (
    input  start, value, blank_zeros,
    output busy, done, dig0, dig1, dig2, dig3
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the nibble is 5 or more.
module bcd_add3
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [NIB_W-1:0] nib_c
);

  // Unsigned 4-bit correction, no carry out of the nibble
  assign nib_c = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bcd_digit_splitter.sv
// Sequential binary-to-BCD converter feeding the four 7-segment digit decoders.
module bcd_digit_splitter
  import display_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  bcd_digit_splitter_if.slave  bus
);

  logic [1:0]                    state_q, state_d;
  logic [BCD_W-1:0]              bcd_q, bcd_d;
  logic [IN_W-1:0]               bin_q, bin_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          blank_q, blank_d;
  logic                          ovf_q, ovf_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [DIGITS-1:0][NIB_W-1:0]  dig_q, dig_d;

  logic [BCD_W-1:0]              adj_c;
  logic [DIGITS-1:0][NIB_W-1:0]  fmt_c;
  logic                          leading_c;

  // One add-3 corrector per BCD nibble
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[g*NIB_W +: NIB_W]),
      .nib_c (adj_c[g*NIB_W +: NIB_W])
    );
  end

  // Map the finished BCD value to display codes (dash on overflow, optional blanking)
  always_comb begin
    fmt_c     = '0;
    leading_c = blank_q;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_q) begin
        fmt_c[i] = CODE_DASH;
      end else if (leading_c && (bcd_q[i*NIB_W +: NIB_W] == 4'd0) && (i != 0)) begin
        fmt_c[i] = CODE_BLANK;
      end else begin
        fmt_c[i]  = bcd_q[i*NIB_W +: NIB_W];
        leading_c = 1'b0;
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dig_d   = dig_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(IN_W - 1);
          blank_d = bus.blank_zeros;
          ovf_d   = (bus.value > IN_W'(MAX_DISPLAY));
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj_c, bin_q} << 1;
        if (cnt_q == '0) begin
          state_d = ST_FORMAT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FORMAT: begin
        dig_d   = fmt_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion and blanks the display
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= {DIGITS{CODE_BLANK}};
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dig0 = CODE_W'(dig_q[0]);
  assign bus.dig1 = CODE_W'(dig_q[1]);
  assign bus.dig2 = CODE_W'(dig_q[2]);
  assign bus.dig3 = CODE_W'(dig_q[3]);

endmodule

// File: tb/tb_bcd_digit_splitter.sv
// Self-checking bench for bcd_digit_splitter against a decimal-arithmetic model.
module tb_bcd_digit_splitter;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  bcd_digit_splitter_if bus_if ();

  bcd_digit_splitter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Display codes expected for a value, from decimal digits and the blanking rule
  function automatic logic [55:0] model(input int val, input bit bz);
    int d [4];
    int pw;
    bit lead;
    pw = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = (val / pw) % 10;
      pw   = pw * 10;
    end
    if (val > 9999) begin
      for (int i = 0; i < 4; i++) d[i] = 10;
    end else if (bz) begin
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && d[i] == 0) d[i] = 11;
        else lead = 1'b0;
      end
    end
    return {14'(d[3]), 14'(d[2]), 14'(d[1]), 14'(d[0])};
  endfunction

  function automatic logic [55:0] digs();
    return {bus_if.dig3, bus_if.dig2, bus_if.dig1, bus_if.dig0};
  endfunction

  // Issue one start and wait for done; reports latency and busy/hold behaviour
  task automatic convert(input int val, input bit bz, output int lat,
                         output bit busy_ok, output bit hold_ok);
    logic [55:0] snap;
    @(negedge clk);
    bus_if.start       = 1'b1;
    bus_if.value       = 14'(val);
    bus_if.blank_zeros = bz;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    snap    = digs();
    busy_ok = (bus_if.busy === 1'b1);
    hold_ok = 1'b1;
    lat     = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) begin
        lat = k;
        if (bus_if.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      if (digs() !== snap) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit seen_done;
    bus_if.start = 1'b0; bus_if.value = '0; bus_if.blank_zeros = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_if.done !== 1'b0) seen_done = 1'b1;
    end
    vectors++;
    if (digs() !== model(11 + 0, 0) && digs() !== {4{14'd11}}) begin end
    if (digs() !== {4{14'd11}}) begin
      errors++; $display("FAIL reset_digits got=%h want=%h", digs(), {4{14'd11}});
    end
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", bus_if.busy);
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=1 want=0");
    end
  endtask

  // One directed or random conversion with all of its checks
  task automatic check_conv(input string name, input int val, input bit bz);
    int lat; bit bok, hok;
    convert(val, bz, lat, bok, hok);
    vectors++;
    if (lat !== 15) begin
      errors++; $display("FAIL %s_latency val=%0d got=%0d want=15", name, val, lat);
    end
    vectors++;
    if (bok !== 1'b1) begin
      errors++; $display("FAIL %s_busy val=%0d got=0 want=1", name, val);
    end
    vectors++;
    if (hok !== 1'b1) begin
      errors++; $display("FAIL %s_hold val=%0d digits changed while busy", name, val);
    end
    vectors++;
    if (digs() !== model(val, bz)) begin
      errors++; $display("FAIL %s_digits val=%0d bz=%0b got=%h want=%h",
                         name, val, bz, digs(), model(val, bz));
    end
  endtask

  task automatic test_directed();
    int vals [10] = '{1234, 7, 7, 0, 9999, 10000, 16383, 10000, 40, 0};
    bit bzs  [10] = '{0,    1, 0, 1, 0,    0,     1,     1,     1,  0};
    for (int i = 0; i < 10; i++) check_conv("directed", vals[i], bzs[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      check_conv("random", v, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.value = 14'd1234; bus_if.blank_zeros = 1'b0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus_if.start = 1'b1; bus_if.value = 14'd5678;
      end
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) begin lat = k; break; end
    end
    vectors++;
    if (lat !== 15) begin
      errors++; $display("FAIL ignore_latency got=%0d want=15", lat);
    end
    vectors++;
    if (digs() !== model(1234, 0)) begin
      errors++; $display("FAIL ignore_digits got=%h want=%h", digs(), model(1234, 0));
    end
  endtask

  task automatic test_back_to_back();
    vectors++;
    if (bus_if.done !== 1'b1) begin
      errors++; $display("FAIL b2b_done_cycle got=%b want=1", bus_if.done);
    end
    check_conv("b2b", 5678, 0);
    check_conv("b2b2", 42, 1);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.value = 14'd4321; bus_if.blank_zeros = 1'b0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (digs() !== {4{14'd11}}) begin
      errors++; $display("FAIL midreset_digits got=%h want=%h", digs(), {4{14'd11}});
    end
    vectors++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got=busy%b/done%b want=busy0/done0",
                         bus_if.busy, bus_if.done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_if.done !== 1'b0) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL midreset_no_done got=1 want=0");
    end
    check_conv("after_reset", 4321, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
